dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Data-memory bridge directly downstream of the MEM stage's load/store port.
//  Turns the single-cycle load/store strobes into a req/ack bus transaction.
//  Buffers stores in a small FIFO write buffer and drains them in order.
//  Produces a stall to the pipeline while a load, or a store into a full buffer, is pending.
// PARAMETERS
//  W        32  word width; equals WORD_WIDTH
//  SB_DEPTH 4   write-buffer entries; must be a power of 2, >=2
//  SB_AW    2   log2(SB_DEPTH)
// PORTS
//  clk       in  1    clock; all state updates on the rising edge
//  rst       in  1    asynchronous, active-low reset
//  load_en   in  1    load request from MEM stage; held while stall=1
//  l_addr    in  W    load word address
//  l_data    out W    load result to MEM stage; registered
//  store_en  in  1    store request from MEM stage; held while stall=1
//  s_addr    in  W    store word address
//  s_data    in  W    store data, already lane-aligned
//  s_be      in  W/8  store byte enables
//  stall     out 1    freeze IF..MEM; combinational
//  bus_req   out 1    bus transaction request
//  bus_we    out 1    1 = write, 0 = read
//  bus_addr  out W    bus word address
//  bus_wdata out W    write data
//  bus_be    out W/8  write byte enables; all ones on reads
//  bus_ack   in  1    one-cycle transaction completion; ignored unless bus_req=1
//  bus_rdata in  W    read data, valid in the bus_ack cycle
// BEHAVIOUR
//  Reset: FIFO empty; FSM=IDLE; ld_done=0; stall, l_data, bus_* all 0, asserted asynchronously.
//   Reset mid-transaction drops bus_req immediately and discards buffered stores.
//  FIFO: rd/wr pointers are SB_AW+1 bits and wrap naturally.
//   empty when ptrs are equal; full when MSBs differ and LSBs are equal.
//  Store: accepted in any cycle with store_en=1 and not full; stall=0; entry {addr,data,be}.
//   Store when full: stall=1 until a drain ack frees a slot.
//   In the ack cycle the enqueue and dequeue happen together; stall=0 in that cycle.
//  Bus: addr/we/wdata/be are stable while bus_req=1. Exactly one ack completes a transaction.
//   bus_req is 0 for at least one cycle after each ack.
//  FSM states:
//   IDLE -> RD when a load needs the bus (below).
//   IDLE -> WR when the FIFO is not empty and no load is pending.
//   WR: bus_req=1, bus_we=1, head entry on the bus; on ack, pop the head -> GAP.
//   RD: bus_req=1, bus_we=0, addr=l_addr; on ack, l_data<=bus_rdata and ld_done<=1 -> GAP.
//   GAP: one idle cycle -> IDLE.
//  Load: stall=1 from the load_en cycle through the ack cycle inclusive.
//   In the following cycle ld_done=1 forces stall=0; the pipeline samples l_data then; ld_done clears.
//   Minimum load latency: 2 stall cycles, with a 1-cycle ack.
//  Ordering: a load never bypasses an older store to the same address.
//  load_en and store_en both high is illegal: the store is taken and the load is ignored.
//  l_data holds its value between loads.
// CONFIGURATION
//  STORE_FWD_EN undefined:
//   Load waits (stall=1) until the FIFO is empty and the FSM is IDLE, then goes to RD.
//  STORE_FWD_EN defined: the load address is compared against all valid entries.
//   Youngest match with be all ones: l_data<=entry data at the edge; stall=0 in the next cycle
//    (1 stall cycle); no bus access.
//   Match with partial be: drain until no entry matches, then RD.
//   No match: RD takes priority over a not-yet-started drain. A WR already in flight completes first.
// TESTING
//  1. Reset with FIFO full and WR in flight -> bus_req=0 immediately; no writes after release.
//  2. Stores to 0x100,0x104,0x108,0x10C, then 0x110 with ack delay 3 -> stall only on the 5th store;
//     bus writes happen in enqueue order.
//  3. FIFO full; 5th store in the drain ack cycle -> stall=0 in that cycle; count stays 4.
//  4. Load 0x200, bus_rdata=0xDEADBEEF, ack after 2 cycles -> stall=1 for 3 cycles;
//     next cycle l_data=0xDEADBEEF with stall=0.
//  5. Store 0x40=0x12345678, be=4'hF, then load 0x40 -> without FWD: WR precedes RD.
//     With FWD: no RD; l_data=0x12345678 after 1 stall cycle.
//  6. FWD: store be=4'h1 to 0x40, then load 0x40 -> drain, then RD; no forwarding.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: data-memory bridge between the MEM-stage load/store port and a
// req/ack bus. Stores are posted into an in-order write buffer and drained in
// the background. Loads stall the pipeline until their data is in l_data.
// Optional build macro STORE_FWD_EN enables load forwarding from the write
// buffer. Without the macro, a load waits for the buffer to drain completely.
module dmem_bridge #(
    parameter int W        = 32,
    parameter int SB_DEPTH = 4,
    parameter int SB_AW    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_en,
    input  logic [W-1:0]   l_addr,
    output logic [W-1:0]   l_data,
    input  logic           store_en,
    input  logic [W-1:0]   s_addr,
    input  logic [W-1:0]   s_data,
    input  logic [W/8-1:0] s_be,
    output logic           stall,
    output logic           bus_req,
    output logic           bus_we,
    output logic [W-1:0]   bus_addr,
    output logic [W-1:0]   bus_wdata,
    output logic [W/8-1:0] bus_be,
    input  logic           bus_ack,
    input  logic [W-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t state;

    // Write-buffer storage and pointers. The pointers carry one extra wrap bit.
    logic [W-1:0]   sb_addr [SB_DEPTH];
    logic [W-1:0]   sb_data [SB_DEPTH];
    logic [W/8-1:0] sb_be   [SB_DEPTH];
    logic [SB_AW:0] wr_ptr;
    logic [SB_AW:0] rd_ptr;
    logic [SB_AW-1:0] head;

    logic empty;
    logic full;
    logic ack;
    logic pop;
    logic push;
    logic ld_done;
    logic load_act;
    logic load_rd;
    logic fwd_take;
    logic [W-1:0] fwd_data;

    assign head  = rd_ptr[SB_AW-1:0];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[SB_AW] != rd_ptr[SB_AW]) &&
                   (wr_ptr[SB_AW-1:0] == rd_ptr[SB_AW-1:0]);

    // An ack only counts while a transaction is actually requested.
    assign ack  = bus_ack & bus_req;
    assign pop  = (state == WR) & ack;

    // A full buffer still accepts a store in the cycle its head drains.
    assign push = store_en & (~full | pop);

    // A simultaneous store wins over a load. ld_done retires the load for one cycle.
    assign load_act = load_en & ~store_en & ~ld_done;

    // Stall the pipeline for a blocked store or an unfinished load.
    assign stall = rst & ((store_en & full & ~pop) | load_act);

`ifdef STORE_FWD_EN
    logic [SB_AW:0] count;
    logic           match_any;
    logic           match_full;

    assign count = wr_ptr - rd_ptr;

    // Scan from oldest to youngest, so the youngest matching entry determines the result.
    always_comb begin
        logic [SB_AW-1:0] idx;
        match_any  = 1'b0;
        match_full = 1'b0;
        fwd_data   = '0;
        idx        = '0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            idx = head + SB_AW'(k);
            if (((SB_AW+1)'(k) < count) && (sb_addr[idx] == l_addr)) begin
                match_any  = 1'b1;
                match_full = &sb_be[idx];
                fwd_data   = sb_data[idx];
            end
        end
    end

    // A partial match must drain until it disappears. A full match never uses the bus.
    assign load_rd  = load_act & ~match_any;
    assign fwd_take = load_act & match_full & (state != RD);
`else
    assign load_rd  = load_act & empty;
    assign fwd_take = 1'b0;
    assign fwd_data = '0;
`endif

    // Buffer pointers: enqueue on accepted store, dequeue on write ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Buffer storage. Stale contents are harmless because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr[SB_AW-1:0]] <= s_addr;
            sb_data[wr_ptr[SB_AW-1:0]] <= s_data;
            sb_be[wr_ptr[SB_AW-1:0]]   <= s_be;
        end
    end

    // Bus FSM with registered bus outputs, plus load completion (l_data, ld_done).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            l_data    <= '0;
            ld_done   <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            if (fwd_take) begin
                l_data  <= fwd_data;
                ld_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load_rd) begin
                        state     <= RD;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= l_addr;
                        bus_wdata <= '0;
                        bus_be    <= '1;
                    end else if (!empty) begin
                        state     <= WR;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= sb_addr[head];
                        bus_wdata <= sb_data[head];
                        bus_be    <= sb_be[head];
                    end
                end
                RD: begin
                    if (ack) begin
                        l_data    <= bus_rdata;
                        ld_done   <= 1'b1;
                        state     <= GAP;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end
                end
                WR: begin
                    if (ack) begin
                        state     <= GAP;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: bench for dmem_bridge. The reference model is a program-order
// byte-enable memory. Each issued store pushes its expected bus write, and each
// issued load pushes its expected data. Monitor processes pop and compare these
// expectations when the bus completes a write or the pipeline retires a load.
module tb_dmem_bridge;

    localparam int W  = 32;
    localparam int BW = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [W-1:0]  l_addr;
    logic [W-1:0]  l_data;
    logic          store_en;
    logic [W-1:0]  s_addr;
    logic [W-1:0]  s_data;
    logic [BW-1:0] s_be;
    logic          stall;
    logic          bus_req;
    logic          bus_we;
    logic [W-1:0]  bus_addr;
    logic [W-1:0]  bus_wdata;
    logic [BW-1:0] bus_be;
    logic          bus_ack;
    logic [W-1:0]  bus_rdata;

    always #5 clk = ~clk;

    dmem_bridge #(.W(W), .SB_DEPTH(4), .SB_AW(2)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
        .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .s_be(s_be),
        .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    int checks   = 0;
    int failures = 0;
    wr_t         wq[$];
    logic [31:0] lq[$];
    logic [31:0] refmem [logic [31:0]];
    logic [31:0] busmem [logic [31:0]];
    int fixed_dly = 0;
    int rd_count  = 0;
    int wr_count  = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rd_bus(input logic [31:0] a);
        return busmem.exists(a) ? busmem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus slave: ack each request after fixed_dly cycles, or a random 0..3 if fixed_dly < 0.
    initial begin : responder
        int age;
        int dly;
        age = 0;
        dly = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            if (!rst || !bus_req) begin
                age = 0;
            end else begin
                if (age == 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                if (age == dly) begin
                    bus_ack = 1'b1;
                    if (!bus_we) bus_rdata = rd_bus(bus_addr);
                end
                age++;
            end
        end
    end

    // Bus monitor: check write order, request stability, and the idle gap after each ack.
    initial begin : bus_monitor
        logic        prev_ack;
        logic        prev_req;
        logic [36:0] snap_ctl;
        logic [31:0] snap_wd;
        wr_t         e;
        prev_ack = 1'b0;
        prev_req = 1'b0;
        snap_ctl = '0;
        snap_wd  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ack = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (prev_ack) check("req_gap_after_ack", 64'(bus_req), 64'd0);
                if (bus_req && !prev_req) begin
                    snap_ctl = {bus_we, bus_be, bus_addr};
                    snap_wd  = bus_wdata;
                end
                if (bus_req && bus_ack) begin
                    check("bus_ctl_stable", 64'({bus_we, bus_be, bus_addr}), 64'(snap_ctl));
                    check("bus_wdata_stable", 64'(bus_wdata), 64'(snap_wd));
                    if (bus_we) begin
                        wr_count++;
                        if (wq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL bus_write_unexpected: got addr %h, expected no write", bus_addr);
                        end else begin
                            e = wq.pop_front();
                            check("bus_write_addr_data", {bus_addr, bus_wdata}, {e.a, e.d});
                            check("bus_write_be", 64'(bus_be), 64'(e.be));
                        end
                        busmem[bus_addr] = merge(rd_bus(bus_addr), bus_wdata, bus_be);
                    end else begin
                        rd_count++;
                        check("bus_read_be", 64'(bus_be), 64'hF);
                    end
                end
                prev_ack = bus_req & bus_ack;
                prev_req = bus_req & ~bus_ack;
            end
        end
    end

    // Load monitor: a load retires in the cycle it is held with stall low.
    initial begin : load_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && load_en && !store_en && !stall) begin
                if (lq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL load_unexpected: got %h, expected no load", l_data);
                end else begin
                    e = lq.pop_front();
                    check("load_data", 64'(l_data), 64'(e));
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int stalls, output logic acc_in_ack);
        wr_t e;
        @(posedge clk);
        #1;
        load_en  = 1'b0;
        store_en = 1'b1;
        s_addr   = a;
        s_data   = d;
        s_be     = be;
        e.a = a;
        e.d = d;
        e.be = be;
        wq.push_back(e);
        refmem[a] = merge(rd_ref(a), d, be);
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL store_timeout: got stall=1 after %0d cycles, expected acceptance", stalls);
        end
        acc_in_ack = bus_ack & bus_we;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        @(posedge clk);
        #1;
        store_en = 1'b0;
        load_en  = 1'b1;
        l_addr   = a;
        lq.push_back(rd_ref(a));
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: got stall=1 after %0d cycles, expected completion", stalls);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        store_en = 1'b0;
        load_en  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((wq.size() != 0 || lq.size() != 0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", 64'(wq.size() + lq.size()), 64'd0);
    endtask

    initial begin : stimulus
        int   st;
        int   rd0;
        logic aa;
        logic seen;
        rst      = 1'b0;
        load_en  = 1'b0;
        store_en = 1'b0;
        l_addr   = '0;
        s_addr   = '0;
        s_data   = '0;
        s_be     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({stall, bus_req, bus_we, bus_be}), 64'd0);
        check("reset_addr_wdata", {bus_addr, bus_wdata}, 64'd0);
        check("reset_ldata", 64'(l_data), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reset while the buffer is full and a write is outstanding.
        fixed_dly = 20;
        for (int i = 0; i < 4; i++) begin
            do_store(32'(32'h80 + i * 4), $urandom, 4'hF, st, aa);
            check("t1_store_no_stall", 64'(st), 64'd0);
        end
        go_idle();
        for (int k = 0; k < 20 && !bus_req; k++) @(negedge clk);
        check("t1_write_in_flight", 64'(bus_req), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t1_req_dropped", 64'({bus_req, stall}), 64'd0);
        wq.delete();
        refmem = busmem;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
        end
        check("t1_no_bus_after_reset", 64'(seen), 64'd0);

        // Four stores fill the buffer. The fifth stalls until a drain ack.
        fixed_dly = 3;
        for (int i = 0; i < 4; i++) begin
            do_store(32'(32'h100 + i * 4), $urandom, 4'hF, st, aa);
            check("t2_store_no_stall", 64'(st), 64'd0);
        end
        do_store(32'h110, $urandom, 4'hF, st, aa);
        check("t2_fifth_store_stalled", 64'(st > 0), 64'd1);
        check("t3_accepted_in_ack_cycle", 64'(aa), 64'd1);
        go_idle();
        drain();

        // Load on an empty buffer, with the ack two cycles after load_en.
        fixed_dly = 1;
        busmem[32'h200] = 32'hDEADBEEF;
        refmem[32'h200] = 32'hDEADBEEF;
        do_load(32'h200, st);
        check("t4_load_stall_cycles", 64'(st), 64'd3);
        go_idle();
        drain();

        // Load after a full-word store to the same address.
        fixed_dly = 0;
        rd0 = rd_count;
        do_store(32'h40, 32'h12345678, 4'hF, st, aa);
        do_load(32'h40, st);
`ifdef STORE_FWD_EN
        check("t5_fwd_stall_cycles", 64'(st), 64'd1);
        check("t5_fwd_no_bus_read", 64'(rd_count - rd0), 64'd0);
`else
        check("t5_one_bus_read", 64'(rd_count - rd0), 64'd1);
`endif
        go_idle();
        drain();

        // A partial-byte store to the load address forces drain, then a bus read.
        rd0 = rd_count;
        do_store(32'h44, 32'hAABBCCDD, 4'h1, st, aa);
        do_load(32'h44, st);
        check("t6_partial_bus_read", 64'(rd_count - rd0), 64'd1);
        go_idle();
        drain();

        // Random mix of loads and stores over a small address window.
        fixed_dly = -1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = 32'(32'h300 + $urandom_range(0, 5) * 4);
            if ($urandom_range(0, 9) < 4) do_load(a, st);
            else do_store(a, $urandom, 4'($urandom_range(0, 15)), st, aa);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
